// File: rtl/serial_2wire_regaccess_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_2wire_regaccess_if
// Purpose  : Word-level link between the register-access sequencer and the
//            serial_2wire controller.
// Revision : 1.0
// ============================================================================
interface serial_2wire_regaccess_if #(
    parameter int BITS = 8
);
    logic            out_ser_enable;
    logic            out_ser_write;
    logic [BITS-1:0] out_ser_parallel;
    logic            out_ser_rst;
    logic            in_ser_ready;
    logic            in_ser_err;
    logic            in_ser_next_word;
    logic            in_ser_word_finished;
    logic [BITS-1:0] in_ser_parallel;

    // Sequencer side
    modport master (
        output out_ser_enable, out_ser_write, out_ser_parallel, out_ser_rst,
        input  in_ser_ready, in_ser_err, in_ser_next_word,
               in_ser_word_finished, in_ser_parallel
    );

    // Controller side
    modport slave (
        input  out_ser_enable, out_ser_write, out_ser_parallel, out_ser_rst,
        output in_ser_ready, in_ser_err, in_ser_next_word,
               in_ser_word_finished, in_ser_parallel
    );
endinterface
`default_nettype wire

// File: rtl/serial_2wire_regaccess.sv
`default_nettype none
// ============================================================================
// Module   : serial_2wire_regaccess
// Purpose  : Turns one register write/read request into the word stream and
//            enable timing of the serial_2wire controller.
// Revision : 1.0
// ============================================================================
module serial_2wire_regaccess #(
    parameter int BITS      = 8,
    parameter int MAX_WRITE = 4
) (
    input  wire                          in_clk,
    input  wire                          in_rst,
    input  wire                          in_start,
    input  wire                          in_read,
    input  wire  [BITS-1:0]              in_reg,
    input  wire  [MAX_WRITE*BITS-1:0]    in_data,
    input  wire  [$clog2(MAX_WRITE+1)-1:0] in_len,
    input  wire                          in_clear,
    output logic                         out_busy,
    output logic                         out_done,
    output logic                         out_err,
    output logic [BITS-1:0]              out_data,
    serial_2wire_regaccess_if.master     ser
);
    localparam int LW = $clog2(MAX_WRITE + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_READY = 3'd1,
        S_XFER       = 3'd2,
        S_READ_PHASE = 3'd3,
        S_WAIT_STOP  = 3'd4,
        S_ERROR      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [BITS-1:0]         rdata_q, rdata_d;
    logic                    en_q, en_d;
    logic                    wr_q, wr_d;
    logic [BITS-1:0]         par_q, par_d;
    logic                    srst_q, srst_d;
    logic                    nw_prev_q, wf_prev_q;
    logic [LW-1:0]           idx_q, idx_d;
    logic                    read_q, read_d;
    logic [BITS-1:0]         reg_q, reg_d;
    logic [MAX_WRITE*BITS-1:0] data_q, data_d;
    logic [LW-1:0]           len_q, len_d;
    logic                    low_seen_q, low_seen_d;

    logic                    nw_rise;
    logic                    wf_rise;
    logic [BITS-1:0]         data_word;

    assign nw_rise = ser.in_ser_next_word     & ~nw_prev_q;
    assign wf_rise = ser.in_ser_word_finished & ~wf_prev_q;

    always_comb begin
        data_word = '0;
        for (int k = 0; k < MAX_WRITE; k++) begin
            if (idx_q == LW'(k)) data_word = data_q[k*BITS +: BITS];
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        en_d       = en_q;
        wr_d       = wr_q;
        par_d      = par_q;
        srst_d     = 1'b0;
        idx_d      = idx_q;
        read_d     = read_q;
        reg_d      = reg_q;
        data_d     = data_q;
        len_d      = len_q;
        low_seen_d = low_seen_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (in_start) begin
                    read_d  = in_read;
                    reg_d   = in_reg;
                    data_d  = in_data;
                    len_d   = (in_len > LW'(MAX_WRITE)) ? LW'(MAX_WRITE) : in_len;
                    busy_d  = 1'b1;
                    state_d = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (ser.in_ser_ready) begin
                    en_d    = 1'b1;
                    par_d   = reg_q;
                    wr_d    = ~read_q;
                    idx_d   = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (read_q) begin
                    wr_d = 1'b0;
                    if (nw_rise) state_d = S_READ_PHASE;
                end else begin
                    wr_d = 1'b1;
                    if (nw_rise) begin
                        if (idx_q == len_q) begin
                            en_d       = 1'b0;
                            low_seen_d = 1'b0;
                            state_d    = S_WAIT_STOP;
                        end else begin
                            par_d = data_word;
                            idx_d = idx_q + LW'(1);
                        end
                    end
                end
            end
            S_READ_PHASE: begin
                if (nw_rise) en_d = 1'b0;
                if (wf_rise) begin
                    rdata_d    = ser.in_ser_parallel;
                    low_seen_d = 1'b0;
                    state_d    = S_WAIT_STOP;
                end
            end
            S_WAIT_STOP: begin
                // Ready right after the enable drop is stale; demand a low sample first.
                if (!ser.in_ser_ready) low_seen_d = 1'b1;
                if (ser.in_ser_ready && !en_q && low_seen_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                en_d   = 1'b0;
                err_d  = 1'b1;
                busy_d = 1'b0;
                if (in_clear) begin
                    srst_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Controller error overrides every other event of an active request.
        if (ser.in_ser_err && (state_q == S_WAIT_READY || state_q == S_XFER ||
                               state_q == S_READ_PHASE || state_q == S_WAIT_STOP)) begin
            en_d    = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            rdata_d = rdata_q;
            state_d = S_ERROR;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            par_q      <= '0;
            srst_q     <= 1'b0;
            nw_prev_q  <= 1'b0;
            wf_prev_q  <= 1'b0;
            idx_q      <= '0;
            read_q     <= 1'b0;
            reg_q      <= '0;
            data_q     <= '0;
            len_q      <= '0;
            low_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            wr_q       <= wr_d;
            par_q      <= par_d;
            srst_q     <= srst_d;
            nw_prev_q  <= ser.in_ser_next_word;
            wf_prev_q  <= ser.in_ser_word_finished;
            idx_q      <= idx_d;
            read_q     <= read_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            len_q      <= len_d;
            low_seen_q <= low_seen_d;
        end
    end

    assign out_busy             = busy_q;
    assign out_done             = done_q;
    assign out_err              = err_q;
    assign out_data             = rdata_q;
    assign ser.out_ser_enable   = en_q;
    assign ser.out_ser_write    = wr_q;
    assign ser.out_ser_parallel = par_q;
    assign ser.out_ser_rst      = srst_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_2wire_regaccess.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_2wire_regaccess
// Purpose  : Directed bench; the controller handshake is driven by hand.
// Revision : 1.0
// ============================================================================
module tb_serial_2wire_regaccess;
    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_start, in_read, in_clear;
    logic [7:0]  in_reg;
    logic [31:0] in_data;
    logic [2:0]  in_len;
    logic        out_busy, out_done, out_err;
    logic [7:0]  out_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_base;

    serial_2wire_regaccess_if #(.BITS(8)) ser_if ();

    serial_2wire_regaccess #(.BITS(8), .MAX_WRITE(4)) dut (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_start (in_start),
        .in_read  (in_read),
        .in_reg   (in_reg),
        .in_data  (in_data),
        .in_len   (in_len),
        .in_clear (in_clear),
        .out_busy (out_busy),
        .out_done (out_done),
        .out_err  (out_err),
        .out_data (out_data),
        .ser      (ser_if)
    );

    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) if (out_done) done_cnt++;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nw_up();
        ser_if.in_ser_next_word = 1'b1;
        tick();
    endtask

    task automatic nw_down();
        tick();
        tick();
        ser_if.in_ser_next_word = 1'b0;
        tick();
    endtask

    task automatic request(input logic rd, input logic [7:0] r,
                           input logic [31:0] d, input logic [2:0] l);
        in_read  = rd;
        in_reg   = r;
        in_data  = d;
        in_len   = l;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    logic [7:0] exp_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        in_rst = 1'b0; in_start = 1'b0; in_read = 1'b0; in_clear = 1'b0;
        in_reg = '0; in_data = '0; in_len = '0;
        ser_if.in_ser_ready = 1'b0; ser_if.in_ser_err = 1'b0;
        ser_if.in_ser_next_word = 1'b0; ser_if.in_ser_word_finished = 1'b0;
        ser_if.in_ser_parallel = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(out_busy), 0);
        chk("rst_en",   32'(ser_if.out_ser_enable), 0);
        chk("rst_par",  32'(ser_if.out_ser_parallel), 0);
        chk("rst_srst", 32'(ser_if.out_ser_rst), 0);
        in_rst = 1'b1;
        ser_if.in_ser_ready = 1'b1;
        tick();

        // Write 0x10 <- AA, 55
        done_base = done_cnt;
        request(1'b0, 8'h10, 32'h0000_55AA, 3'd2);
        chk("wr_busy", 32'(out_busy), 1);
        tick();
        chk("wr_en",   32'(ser_if.out_ser_enable), 1);
        chk("wr_reg",  32'(ser_if.out_ser_parallel), 32'h10);
        chk("wr_wr",   32'(ser_if.out_ser_write), 1);
        ser_if.in_ser_ready = 1'b0;
        nw_up(); chk("wr_b0", 32'(ser_if.out_ser_parallel), 32'hAA); nw_down();
        nw_up(); chk("wr_b1", 32'(ser_if.out_ser_parallel), 32'h55); nw_down();
        nw_up(); chk("wr_endis", 32'(ser_if.out_ser_enable), 0); nw_down();
        ser_if.in_ser_ready = 1'b1;
        tick();
        chk("wr_done", 32'(out_done), 1);
        chk("wr_idle", 32'(out_busy), 0);
        tick();
        chk("wr_done_pulse", 32'(out_done), 0);
        chk("wr_done_cnt", 32'(done_cnt - done_base), 1);
        chk("wr_err", 32'(out_err), 0);

        // Read 0x20, target returns 3C
        request(1'b1, 8'h20, 32'h0, 3'd0);
        tick();
        chk("rd_en",  32'(ser_if.out_ser_enable), 1);
        chk("rd_reg", 32'(ser_if.out_ser_parallel), 32'h20);
        chk("rd_wr",  32'(ser_if.out_ser_write), 0);
        ser_if.in_ser_ready = 1'b0;
        nw_up(); chk("rd_keep_en", 32'(ser_if.out_ser_enable), 1); nw_down();
        nw_up(); chk("rd_drop_en", 32'(ser_if.out_ser_enable), 0); nw_down();
        ser_if.in_ser_parallel = 8'h3C;
        ser_if.in_ser_word_finished = 1'b1;
        tick();
        ser_if.in_ser_word_finished = 1'b0;
        tick();
        ser_if.in_ser_ready = 1'b1;
        tick();
        chk("rd_done", 32'(out_done), 1);
        chk("rd_data", 32'(out_data), 32'h3C);

        // Pointer-set write (len 0); stale ready must not complete the request
        request(1'b0, 8'h07, 32'h0, 3'd0);
        tick();
        chk("ps_reg", 32'(ser_if.out_ser_parallel), 32'h07);
        ser_if.in_ser_ready = 1'b0;
        tick();
        nw_up();
        chk("ps_endis", 32'(ser_if.out_ser_enable), 0);
        ser_if.in_ser_ready = 1'b1;
        tick();
        chk("ps_stale_ready", 32'(out_done), 0);
        ser_if.in_ser_ready = 1'b0;
        tick();
        ser_if.in_ser_ready = 1'b1;
        tick();
        chk("ps_done", 32'(out_done), 1);
        ser_if.in_ser_next_word = 1'b0;
        tick();

        // Address NAK -> Error, clear, then a good write
        request(1'b0, 8'h30, 32'h01, 3'd1);
        tick();
        chk("nak_en", 32'(ser_if.out_ser_enable), 1);
        ser_if.in_ser_ready = 1'b0;
        ser_if.in_ser_err = 1'b1;
        done_base = done_cnt;
        tick();
        chk("nak_err",  32'(out_err), 1);
        chk("nak_en0",  32'(ser_if.out_ser_enable), 0);
        chk("nak_busy", 32'(out_busy), 0);
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        chk("nak_start_ign", 32'(out_busy), 0);
        tick();
        chk("nak_no_done", 32'(done_cnt - done_base), 0);
        in_clear = 1'b1;
        tick();
        in_clear = 1'b0;
        chk("clr_srst", 32'(ser_if.out_ser_rst), 1);
        chk("clr_err",  32'(out_err), 0);
        ser_if.in_ser_err = 1'b0;
        tick();
        chk("clr_srst_1cyc", 32'(ser_if.out_ser_rst), 0);
        ser_if.in_ser_ready = 1'b1;
        request(1'b0, 8'h31, 32'h5A, 3'd1);
        tick();
        ser_if.in_ser_ready = 1'b0;
        nw_up(); chk("post_b0", 32'(ser_if.out_ser_parallel), 32'h5A); nw_down();
        nw_up(); chk("post_endis", 32'(ser_if.out_ser_enable), 0); nw_down();
        ser_if.in_ser_ready = 1'b1;
        tick();
        chk("post_done", 32'(out_done), 1);
        chk("post_err", 32'(out_err), 0);

        // Start while busy is ignored; len 7 clamps to 4
        ser_if.in_ser_ready = 1'b0;
        request(1'b0, 8'h40, 32'h4433_2211, 3'd7);
        chk("clamp_busy", 32'(out_busy), 1);
        in_reg = 8'h50;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        chk("busy_start_en", 32'(ser_if.out_ser_enable), 0);
        ser_if.in_ser_ready = 1'b1;
        tick();
        chk("busy_start_reg", 32'(ser_if.out_ser_parallel), 32'h40);
        ser_if.in_ser_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nw_up();
            chk($sformatf("clamp_b%0d", k), 32'(ser_if.out_ser_parallel), 32'(exp_bytes[k]));
            chk($sformatf("clamp_en%0d", k), 32'(ser_if.out_ser_enable), 1);
            nw_down();
        end
        nw_up(); chk("clamp_endis", 32'(ser_if.out_ser_enable), 0); nw_down();
        ser_if.in_ser_ready = 1'b1;
        tick();
        chk("clamp_done", 32'(out_done), 1);

        // Asynchronous reset mid-transfer
        request(1'b0, 8'h60, 32'h0000_BBAA, 3'd2);
        tick();
        ser_if.in_ser_ready = 1'b0;
        nw_up();
        chk("mid_b0", 32'(ser_if.out_ser_parallel), 32'hAA);
        #2 in_rst = 1'b0;
        #1;
        chk("arst_busy", 32'(out_busy), 0);
        chk("arst_en",   32'(ser_if.out_ser_enable), 0);
        chk("arst_wr",   32'(ser_if.out_ser_write), 0);
        chk("arst_par",  32'(ser_if.out_ser_parallel), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_err",  32'(out_err), 0);
        in_rst = 1'b1;
        ser_if.in_ser_next_word = 1'b0;
        tick();
        chk("arst_idle", 32'(out_busy), 0);
        ser_if.in_ser_ready = 1'b1;
        request(1'b0, 8'h61, 32'h0, 3'd0);
        chk("arst_accept", 32'(out_busy), 1);
        tick();
        chk("arst_en_again", 32'(ser_if.out_ser_enable), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
